// File: rtl/alu_iq_pkg.sv
// alu_iq_pkg: default widths, reference entry layout and width helpers
// shared by the ALU issue queue and its slots.
package alu_iq_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 6;
    localparam int DEF_FUNC_W = 6;

    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] op1_data;
        logic [DEF_TAG_W-1:0]  op1_tag;
        logic                  op1_vld;
        logic [DEF_DATA_W-1:0] op2_data;
        logic [DEF_TAG_W-1:0]  op2_tag;
        logic                  op2_vld;
        logic [DEF_TAG_W-1:0]  rd_tag;
        logic                  rd_vld;
        logic [DEF_FUNC_W-1:0] func;
    } rs_entry_t;

    // Packed entry width for arbitrary field widths, same field order as rs_entry_t.
    function automatic int ent_w(int data_w, int tag_w, int func_w);
        return 2 * (data_w + tag_w + 1) + tag_w + func_w + 2;
    endfunction

    function automatic int iss_w(int data_w, int tag_w, int func_w);
        return 2 * data_w + tag_w + func_w + 1;
    endfunction

endpackage

// File: rtl/rs_entry_slot.sv
// rs_entry_slot: one reservation-station slot; picks hold/shift/dispatch/clear
// and captures missing operands from the CDB on the chosen candidate.
module rs_entry_slot
    import alu_iq_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  TAG_W  = DEF_TAG_W,
    parameter int  FUNC_W = DEF_FUNC_W,
    localparam int EW     = ent_w(DATA_W, TAG_W, FUNC_W),
    localparam int IW     = iss_w(DATA_W, TAG_W, FUNC_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              take_above,
    input  logic              take_disp,
    input  logic [EW-1:0]     above_i,
    input  logic [EW-1:0]     disp_i,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [EW-1:0]     ent_o,
    output logic [IW-1:0]     iss_o,
    output logic              rdy_o
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] op1_data;
        logic [TAG_W-1:0]  op1_tag;
        logic              op1_vld;
        logic [DATA_W-1:0] op2_data;
        logic [TAG_W-1:0]  op2_tag;
        logic              op2_vld;
        logic [TAG_W-1:0]  rd_tag;
        logic              rd_vld;
        logic [FUNC_W-1:0] func;
    } slot_t;

    slot_t ent_q, ent_d, cand;

    // Wakeup is applied to whatever lands here, so shifted and newly dispatched entries also capture.
    always_comb begin
        cand  = take_disp ? slot_t'(disp_i) : take_above ? slot_t'(above_i) : ent_q;
        ent_d = cand;
        if (cand.valid && !cand.op1_vld && cdb_valid && cand.op1_tag == cdb_tag) begin
            ent_d.op1_data = cdb_data;
            ent_d.op1_vld  = 1'b1;
        end
        if (cand.valid && !cand.op2_vld && cdb_valid && cand.op2_tag == cdb_tag) begin
            ent_d.op2_data = cdb_data;
            ent_d.op2_vld  = 1'b1;
        end
        if (flush) ent_d = '0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) ent_q <= '0;
        else      ent_q <= ent_d;

    assign ent_o = ent_q;
    assign iss_o = {ent_q.op1_data, ent_q.op2_data, ent_q.rd_tag, ent_q.rd_vld, ent_q.func};
    assign rdy_o = ent_q.valid & ent_q.op1_vld & ent_q.op2_vld;

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing, age-ordered ALU reservation station with CDB
// wakeup and oldest-ready select over a valid/ready issue port.
module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int FUNC_W = DEF_FUNC_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [DATA_W-1:0] disp_op1_data,
    input  logic [DATA_W-1:0] disp_op2_data,
    input  logic [TAG_W-1:0]  disp_op1_tag,
    input  logic [TAG_W-1:0]  disp_op2_tag,
    input  logic              disp_op1_vld,
    input  logic              disp_op2_vld,
    input  logic [TAG_W-1:0]  disp_rd_tag,
    input  logic              disp_rd_tag_vld,
    input  logic [FUNC_W-1:0] disp_func,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [DATA_W-1:0] issue_op1,
    output logic [DATA_W-1:0] issue_op2,
    output logic [TAG_W-1:0]  issue_rd_tag,
    output logic              issue_rd_tag_vld,
    output logic [FUNC_W-1:0] issue_func,
    output logic [CNT_W-1:0]  count
);

    localparam int EW = ent_w(DATA_W, TAG_W, FUNC_W);
    localparam int IW = iss_w(DATA_W, TAG_W, FUNC_W);
    localparam int SW = $clog2(DEPTH);

    logic [EW-1:0]    ent_v [DEPTH+1];
    logic [IW-1:0]    iss_v [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [SW-1:0]    sel;
    logic [CNT_W-1:0] count_q, count_d, wr_idx;
    logic [EW-1:0]    disp_e;
    logic             fire, acc;

    assign ent_v[DEPTH] = '0;
    assign disp_e       = {1'b1, disp_op1_data, disp_op1_tag, disp_op1_vld,
                           disp_op2_data, disp_op2_tag, disp_op2_vld,
                           disp_rd_tag, disp_rd_tag_vld, disp_func};
    assign disp_ready   = count_q != CNT_W'(DEPTH);
    assign acc          = disp_valid & disp_ready;
    assign issue_valid  = |rdy;
    assign fire         = issue_valid & issue_ready;
    assign wr_idx       = count_q - CNT_W'(fire);
    assign count        = count_q;
    assign {issue_op1, issue_op2, issue_rd_tag, issue_rd_tag_vld, issue_func} = iss_v[sel];

    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (rdy[i]) sel = SW'(i);
    end

    always_comb begin
        count_d = flush ? '0 : count_q + CNT_W'(acc) - CNT_W'(fire);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;

    // Slots at and above the issued one pull from their upper neighbour; the top slot pulls in zeros.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rs_entry_slot #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .FUNC_W (FUNC_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .take_above (fire && SW'(g) >= sel),
            .take_disp  (acc && CNT_W'(g) == wr_idx),
            .above_i    (ent_v[g+1]),
            .disp_i     (disp_e),
            .cdb_valid  (cdb_valid),
            .cdb_tag    (cdb_tag),
            .cdb_data   (cdb_data),
            .ent_o      (ent_v[g]),
            .iss_o      (iss_v[g]),
            .rdy_o      (rdy[g])
        );
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed and randomized stimulus for alu_issue_queue,
// checked against an age-ordered queue model of the reservation station.
module tb_alu_issue_queue;
    import alu_iq_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int FUNC_W = 6;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [DATA_W-1:0] disp_op1_data, disp_op2_data;
    logic [TAG_W-1:0]  disp_op1_tag, disp_op2_tag;
    logic              disp_op1_vld, disp_op2_vld;
    logic [TAG_W-1:0]  disp_rd_tag;
    logic              disp_rd_tag_vld;
    logic [FUNC_W-1:0] disp_func;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_op1, issue_op2;
    logic [TAG_W-1:0]  issue_rd_tag;
    logic              issue_rd_tag_vld;
    logic [FUNC_W-1:0] issue_func;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    alu_issue_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .FUNC_W (FUNC_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .disp_valid       (disp_valid),
        .disp_ready       (disp_ready),
        .disp_op1_data    (disp_op1_data),
        .disp_op2_data    (disp_op2_data),
        .disp_op1_tag     (disp_op1_tag),
        .disp_op2_tag     (disp_op2_tag),
        .disp_op1_vld     (disp_op1_vld),
        .disp_op2_vld     (disp_op2_vld),
        .disp_rd_tag      (disp_rd_tag),
        .disp_rd_tag_vld  (disp_rd_tag_vld),
        .disp_func        (disp_func),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_op1        (issue_op1),
        .issue_op2        (issue_op2),
        .issue_rd_tag     (issue_rd_tag),
        .issue_rd_tag_vld (issue_rd_tag_vld),
        .issue_func       (issue_func),
        .count            (count)
    );

    rs_entry_t q[$];
    int        n_cmp = 0;
    int        n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ready_idx();
        foreach (q[i])
            if (q[i].op1_vld && q[i].op2_vld) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        int k;
        k = ready_idx();
        chk("count", 64'(count), 64'(q.size()));
        chk("disp_ready", 64'(disp_ready), 64'(q.size() < DEPTH));
        chk("issue_valid", 64'(issue_valid), 64'(k >= 0));
        if (k >= 0) begin
            chk("issue_op1", 64'(issue_op1), 64'(q[k].op1_data));
            chk("issue_op2", 64'(issue_op2), 64'(q[k].op2_data));
            chk("issue_rd_tag", 64'(issue_rd_tag), 64'(q[k].rd_tag));
            chk("issue_rd_vld", 64'(issue_rd_tag_vld), 64'(q[k].rd_vld));
            chk("issue_func", 64'(issue_func), 64'(q[k].func));
        end
    endtask

    // Check the current cycle, then advance the model across one rising edge.
    task automatic step();
        int        k, sz;
        rs_entry_t e;
        check_outputs();
        @(posedge clk);
        if (flush) q.delete();
        else begin
            k  = ready_idx();
            sz = q.size();
            if (k >= 0 && issue_ready) q.delete(k);
            if (disp_valid && sz < DEPTH) begin
                e = '{valid: 1'b1, op1_data: disp_op1_data, op1_tag: disp_op1_tag, op1_vld: disp_op1_vld,
                      op2_data: disp_op2_data, op2_tag: disp_op2_tag, op2_vld: disp_op2_vld,
                      rd_tag: disp_rd_tag, rd_vld: disp_rd_tag_vld, func: disp_func};
                q.push_back(e);
            end
            if (cdb_valid)
                foreach (q[i]) begin
                    if (!q[i].op1_vld && q[i].op1_tag == cdb_tag) begin
                        q[i].op1_data = cdb_data;
                        q[i].op1_vld  = 1'b1;
                    end
                    if (!q[i].op2_vld && q[i].op2_tag == cdb_tag) begin
                        q[i].op2_data = cdb_data;
                        q[i].op2_vld  = 1'b1;
                    end
                end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0; cdb_valid = 1'b0;
        disp_op1_data = '0; disp_op1_tag = '0; disp_op1_vld = 1'b0;
        disp_op2_data = '0; disp_op2_tag = '0; disp_op2_vld = 1'b0;
        disp_rd_tag = '0; disp_rd_tag_vld = 1'b0; disp_func = '0;
        cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic disp(input logic [DATA_W-1:0] d1, input int t1, input logic v1,
                        input logic [DATA_W-1:0] d2, input int t2, input logic v2,
                        input int rd, input int f);
        disp_valid = 1'b1;
        disp_op1_data = d1; disp_op1_tag = TAG_W'(t1); disp_op1_vld = v1;
        disp_op2_data = d2; disp_op2_tag = TAG_W'(t2); disp_op2_vld = v2;
        disp_rd_tag = TAG_W'(rd); disp_rd_tag_vld = 1'b1; disp_func = FUNC_W'(f);
    endtask

    task automatic cdb(input int t, input logic [DATA_W-1:0] d);
        cdb_valid = 1'b1; cdb_tag = TAG_W'(t); cdb_data = d;
    endtask

    task automatic rand_inputs();
        flush           = $urandom_range(0, 99) < 3;
        disp_valid      = $urandom_range(0, 99) < 70;
        disp_op1_data   = $urandom;
        disp_op1_tag    = TAG_W'($urandom_range(0, 7));
        disp_op1_vld    = 1'($urandom_range(0, 1));
        disp_op2_data   = $urandom;
        disp_op2_tag    = TAG_W'($urandom_range(0, 7));
        disp_op2_vld    = 1'($urandom_range(0, 1));
        disp_rd_tag     = TAG_W'($urandom);
        disp_rd_tag_vld = 1'($urandom_range(0, 1));
        disp_func       = FUNC_W'($urandom);
        cdb_valid       = 1'($urandom_range(0, 1));
        cdb_tag         = TAG_W'($urandom_range(0, 7));
        cdb_data        = $urandom;
        issue_ready     = $urandom_range(0, 99) < 60;
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_op1", 64'(issue_op1), 64'd0);
        rst = 1'b1;

        // Basic ready dispatch, 1-cycle latency, issue drains it.
        disp(5, 0, 1'b1, 7, 0, 1'b1, 3, 1); step();
        idle(); issue_ready = 1'b1;
        chk("basic_op1", 64'(issue_op1), 64'd5);
        chk("basic_op2", 64'(issue_op2), 64'd7);
        chk("basic_rd", 64'(issue_rd_tag), 64'd3);
        step();
        idle(); step();

        // Younger ready entry overtakes older waiting one; CDB then wakes the older.
        disp(0, 9, 1'b0, 2, 0, 1'b1, 10, 2); step();
        disp(3, 0, 1'b1, 4, 0, 1'b1, 11, 3); step();
        idle(); issue_ready = 1'b1; step();
        idle(); issue_ready = 1'b1; cdb(9, 32'hAA); step();
        idle(); issue_ready = 1'b1;
        chk("wake_op1", 64'(issue_op1), 64'hAA);
        step();

        // Fill, drop the fifth, issue slot 1, then drain in age order.
        for (int i = 0; i < 5; i++) begin
            idle();
            disp(32'h100 + i, (i == 1) ? 21 : 40, 1'b0, 32'h200 + i, 0, 1'b1, 20 + i, i);
            step();
        end
        chk("full_ready", 64'(disp_ready), 64'd0);
        idle(); cdb(21, 32'h11); step();
        idle(); issue_ready = 1'b1; step();
        idle(); cdb(40, 32'h44); step();
        for (int i = 0; i < 4; i++) begin
            idle(); issue_ready = 1'b1; step();
        end

        // Dispatch bypass from the CDB in the dispatch cycle.
        idle(); disp(6, 0, 1'b1, 0, 12, 1'b0, 13, 4); cdb(12, 32'h55); step();
        idle();
        chk("bypass_op2", 64'(issue_op2), 64'h55);
        issue_ready = 1'b1; step();

        // Issue slot 0, dispatch and wake slot 2 all in one cycle.
        idle(); disp(1, 0, 1'b1, 1, 0, 1'b1, 30, 5); step();
        idle(); disp(2, 30, 1'b0, 2, 0, 1'b1, 31, 6); step();
        idle(); disp(3, 31, 1'b0, 3, 0, 1'b1, 32, 7); step();
        idle(); issue_ready = 1'b1; disp(4, 50, 1'b0, 4, 0, 1'b1, 33, 8); cdb(31, 32'h77); step();
        idle();
        chk("concur_rd", 64'(issue_rd_tag), 64'd32);
        step();

        // Flush with a concurrent dispatch.
        idle(); flush = 1'b1; disp(9, 0, 1'b1, 9, 0, 1'b1, 34, 9); step();
        idle(); step();

        for (int n = 0; n < 4000; n++) begin
            rand_inputs();
            step();
        end

        // Asynchronous reset in the middle of a cycle.
        for (int n = 0; n < 6; n++) begin
            rand_inputs(); flush = 1'b0; disp_valid = 1'b1; issue_ready = 1'b0;
            disp_op1_vld = 1'b1; disp_op2_vld = 1'b1;
            step();
        end
        idle();
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(issue_valid), 64'd0);
        chk("arst_ready", 64'(disp_ready), 64'd1);
        chk("arst_op1", 64'(issue_op1), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 200; n++) begin
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Parametrised, collapsing reservation-station queue for the ALU issue path. It accepts dispatched ALU micro-ops with operand values or producer tags, and captures missing operands by tag match on the CDB. Each cycle it offers the oldest entry with both operands valid to the ALU through a valid/ready handshake, compacting the remaining entries so that age order is kept. It replaces the per-entry, externally controlled register chain with a self-contained queue of configurable depth and width, with internal tag compare.

## Interface
- DEPTH, 4: number of entries (≥2).
- DATA_W, 32: operand width.
- TAG_W, 6: ROB/rename tag width.
- FUNC_W, 6: opcode field width ({funct3, alu_ext}).
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  equals !full; a dispatch is accepted when disp_valid & disp_ready.
- disp_op1_data / disp_op2_data  in  DATA_W  operand value.
- disp_op1_tag / disp_op2_tag  in  TAG_W  producer tag.
- disp_op1_vld / disp_op2_vld  in  1  operand value valid.
- disp_rd_tag  in  TAG_W; disp_rd_tag_vld  in  1  destination tag.
- disp_func  in  FUNC_W  opcode field.
- cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_data  in  DATA_W  result broadcast.
- issue_valid  out  1  an entry is ready.
- issue_ready  in  1  ALU accepts.
- issue_op1, issue_op2  out  DATA_W; issue_rd_tag  out  TAG_W; issue_rd_tag_vld  out  1; issue_func  out  FUNC_W.
- count  out  CNT_W  occupied entries.

## Operation
- Entries occupy slots 0..count-1 contiguously. Slot 0 is the oldest.
- Wakeup: every valid entry operand with vld=0, cdb_valid=1 and tag==cdb_tag latches cdb_data and sets vld. This also applies to entries that shift in the same cycle.
- Dispatch bypass: if a dispatched operand has vld=0 and matches the CDB in its dispatch cycle, it is written with cdb_data and vld=1.
- Select: the lowest-index valid entry with op1_vld & op2_vld drives the issue_* outputs combinationally. issue_valid=0 when no entry is ready, and the issue_* data outputs are then don't-care.
- Issue fires on issue_valid & issue_ready. The selected slot k is removed, slots k+1..count-1 move to k..count-2, and count decrements.
- Dispatch writes slot count, or slot count-1 when an issue fires in the same cycle. count changes by +1, 0 or −1 accordingly.
- Full (count==DEPTH): disp_ready=0 and the dispatch is dropped. There is no same-cycle issue-to-dispatch bypass when full.
- Flush: all entries become invalid and count=0 on the next edge. Flush overrides dispatch, issue and wakeup. issue_valid is not masked by flush in the flush cycle, and the consumer ignores it.
- Reset (rst=0, at any time): all entry fields and count go to 0 immediately. disp_ready=1 and issue_valid=0.

## Timing
- All state is registered on the rising edge of clk. The select/issue path is combinational from state.
- Dispatch with both operands valid: issue_valid can assert in the next cycle, so minimum latency is 1.
- A CDB wakeup in cycle t makes the entry eligible in cycle t+1. There is no same-cycle CDB-to-issue forwarding.
- disp_ready depends only on count, not on issue_ready in the same cycle.
- Simultaneous dispatch, issue and wakeup in one cycle are all honoured. Wakeup applies to the post-shift position of each entry.

## Structure
- Shared package alu_iq_pkg: default width constants, and typedef rs_entry_t {valid, op1/op2 data, tag and vld, rd tag and vld, func}.
- Sub-module rs_entry_slot: one slot holding the next-value mux (hold / shift-from-above / dispatch-write / clear) and the per-operand CDB tag comparators.
- The top level instantiates DEPTH slots and contains the ready priority encoder, the shift-control decode and the counter.

## Test plan
- Reset then dispatch {op1=5, vld; op2=7, vld; rd=3}: 1 cycle later issue_valid=1, issue_op1=5, issue_op2=7, issue_rd_tag=3. After issue_ready, count=0.
- Dispatch A (op1 tag 9, invalid) then B (ready): B issues first. cdb{9, 0xAA} then makes A issue the next cycle with op1=0xAA.
- Fill to DEPTH=4 with issue_ready=0: disp_ready=0 and a 5th dispatch is dropped (count stays 4). Then issue slot 1: the order of slots 0, 2, 3 is preserved and count=3.
- Dispatch op2 tag 12 (invalid) in the same cycle as cdb{12, 0x55}: the entry is ready the next cycle with op2=0x55.
- Same cycle: issue slot 0, dispatch new, and CDB wakes slot 2. The result is count unchanged, the new entry in the last slot, and the woken entry shifted to slot 1 with valid data.
- Flush with 3 entries and a concurrent dispatch: count=0 and issue_valid=0 next cycle. Assert rst mid-stream: outputs zero asynchronously.
